mem_slave_responder: RTL

- Slave-side responder for the interconnect's valid/ready write channel. Each instance sits behind one slave port (valid_slaveN / ready_slaveN / addr_out / value_out).
- Accepts single-beat writes after a programmable number of wait states, stores them in an 8-entry register file, and returns a one-cycle ready pulse that completes the handshake.
- Detects and records master-side protocol violations.
- Provides a combinational read-back port for checking memory contents.

---
 rtl/mem_slave_responder_if.sv | 26 ++
 rtl/mem_slave_responder.sv | 131 +++++++++++++
 2 files changed

// File: rtl/mem_slave_responder_if.sv
// Valid/ready single-beat write channel between an interconnect slave port and its responder.
interface mem_slave_responder_if #(
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DATA_W = 3
) ();

    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] value;
    logic              ready;

    modport master (
        output valid,
        output addr,
        output value,
        input  ready
    );

    modport slave (
        input  valid,
        input  addr,
        input  value,
        output ready
    );

endinterface

// File: rtl/mem_slave_responder.sv
// Slave-side write responder: programmable wait states, 8-entry register file,
// one-cycle ready pulse, sticky master protocol-violation flag.
module mem_slave_responder #(
    parameter int unsigned ADDR_W      = 3,
    parameter int unsigned DATA_W      = 3,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_slave_responder_if.slave  bus,
    input  logic                  i_stall,
    output logic                  o_busy,
    input  logic [ADDR_W-1:0]     i_rd_addr,
    output logic [DATA_W-1:0]     o_rd_data,
    output logic [CNT_W-1:0]      o_wr_count,
    output logic                  o_proto_err
);

    localparam int unsigned Depth = 2 ** ADDR_W;
    localparam int unsigned CntW  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] WrCountMax = '1;

    typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

    state_e            r_state;
    state_e            w_state_d;
    logic [CntW-1:0]   r_cnt;
    logic [CntW-1:0]   w_cnt_d;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_value;
    logic [DATA_W-1:0] r_mem [Depth];
    logic [CNT_W-1:0]  r_wr_count;
    logic              r_proto_err;
    logic              r_ready;
    logic              r_busy;

    logic w_latch;
    logic w_commit;
    logic w_err_set;
    logic w_mismatch;

    always_comb begin
        w_state_d  = r_state;
        w_cnt_d    = r_cnt;
        w_latch    = 1'b0;
        w_commit   = 1'b0;
        w_err_set  = 1'b0;
        w_mismatch = (bus.addr != r_addr) || (bus.value != r_value);
        unique case (r_state)
            StIdle: begin
                if (bus.valid && !i_stall) begin
                    w_latch = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        w_state_d = StAck;
                    end else begin
                        w_state_d = StWait;
                        w_cnt_d   = CntW'(WAIT_CYCLES - 1);
                    end
                end
            end
            StWait: begin
                if (!bus.valid) begin
                    w_err_set = 1'b1;
                    w_state_d = StIdle;
                end else begin
                    w_err_set = w_mismatch;
                    if (!i_stall) begin
                        if (r_cnt == '0) begin
                            w_state_d = StAck;
                        end else begin
                            w_cnt_d = r_cnt - 1'b1;
                        end
                    end
                end
            end
            StAck: begin
                // Stall is ignored here: the ready pulse is already committed.
                w_state_d = StIdle;
                if (bus.valid) begin
                    w_commit  = 1'b1;
                    w_err_set = w_mismatch;
                end else begin
                    w_err_set = 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_value     <= '0;
            r_wr_count  <= '0;
            r_proto_err <= 1'b0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            for (int i = 0; i < Depth; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_ready <= (w_state_d == StAck);
            r_busy  <= (w_state_d != StIdle);
            if (w_latch) begin
                r_addr  <= bus.addr;
                r_value <= bus.value;
            end
            if (w_commit) begin
                r_mem[r_addr] <= r_value;
                if (r_wr_count != WrCountMax) begin
                    r_wr_count <= r_wr_count + 1'b1;
                end
            end
            if (w_err_set) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign bus.ready   = r_ready;
    assign o_busy      = r_busy;
    assign o_rd_data   = r_mem[i_rd_addr];
    assign o_wr_count  = r_wr_count;
    assign o_proto_err = r_proto_err;

endmodule
